l2_eviction_buffer: RTL and testbench

- Write-back buffer between the L2 cache and physical memory.
- Absorbs dirty 128-bit victim lines from the L2, so the L2 miss read to pmem proceeds without waiting for the writeback.
- Forwards L2 line reads to pmem, or serves them from the buffer on an address match.
- Drains buffered lines to pmem in FIFO order when pmem is otherwise idle.

---
 rtl/l2_eviction_buffer_pkg.sv | 23 ++
 rtl/l2_eviction_buffer_entry_array.sv | 83 ++++++++
 rtl/l2_eviction_buffer.sv | 192 +++++++++++++++++++
 tb/tb_l2_eviction_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_eviction_buffer_pkg.sv
// Shared types for the LC-3b L2 write-back path.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [11:0]  lc3b_c2_line_tag;
    typedef logic [127:0] lc3b_c2_line;

    typedef enum logic [1:0] {
        IDLE,
        RD_MEM,
        WR_MEM
    } lc3b_evb_state;

    // Line addresses are 16-byte aligned; the low nibble is never meaningful.
    localparam lc3b_word LINE_ADDR_MASK = 16'hFFF0;

    function automatic lc3b_c2_line_tag line_tag(input lc3b_word addr);
        return addr[15:4];
    endfunction

endpackage

// File: rtl/l2_eviction_buffer_entry_array.sv
// Storage for eviction-buffer entries (valid, line tag, line data) plus tag lookup.
// Latency: lookup and head read are combinational; write/clear take effect next cycle.
// Backpressure: none; the owner decides when to write or clear.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset (clears valid bits)
//   wr_en/wr_idx/wr_tag/wr_data write port, used for both allocate and coalesce
//   clr_en/clr_idx             clear port, used when the head is popped
//   lookup_tag                 tag compared against every valid entry
//   match_vec/match_idx        per-entry hit vector and lowest hitting index
//   match_data                 data of the entry at match_idx
//   head_idx/head_tag/head_data read port for the entry being drained
module evb_entry_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [11:0]       wr_tag,
    input  logic [127:0]      wr_data,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx,
    input  logic [11:0]       lookup_tag,
    output logic [DEPTH-1:0]  match_vec,
    output logic [IDX_W-1:0]  match_idx,
    output logic [127:0]      match_data,
    input  logic [IDX_W-1:0]  head_idx,
    output logic [11:0]       head_tag,
    output logic [127:0]      head_data
);

    logic [DEPTH-1:0] valid;
    lc3b_c2_line_tag  tag_q  [DEPTH];
    lc3b_c2_line      data_q [DEPTH];

    // A pop and a write never land in the same cycle, so the order of the
    // two updates below does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (clr_en) begin
                valid[clr_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only ever observed through a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Coalescing keeps tags unique, so at most one bit of match_vec is set;
    // the lowest-index pick is only there to make the encoder well defined.
    always_comb begin
        logic found;
        found     = 1'b0;
        match_vec = '0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid[i] && (tag_q[i] == lookup_tag);
            if (match_vec[i] && !found) begin
                found     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign match_data = data_q[match_idx];
    assign head_tag   = tag_q[head_idx];
    assign head_data  = data_q[head_idx];

endmodule

// File: rtl/l2_eviction_buffer.sv
// Write-back buffer between L2 and pmem: absorbs dirty victims, forwards/serves reads, drains FIFO-order.
// Latency: buffered write or forwarded read -> l2_resp 1 cycle after acceptance; pmem reads -> 1 cycle after pmem_resp.
// Backpressure: L2 holds its request until l2_resp; writes stall while full or while a drain is in flight.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   l2_read/l2_write/l2_address     held line request from the L2 (address low nibble ignored)
//   l2_wdata                        victim line data
//   l2_rdata/l2_resp                registered read data and one-cycle completion pulse
//   pmem_read/pmem_write            pmem line request, held until pmem_resp
//   pmem_address/pmem_wdata         pmem line address (low nibble 0) and write data
//   pmem_rdata/pmem_resp            pmem read data and completion pulse
//
// Build option: define L2_EVB_FORWARD_EN to serve reads that hit a buffered
// line straight from the buffer; without it such reads first force the line
// out to pmem and then read it back.
module l2_eviction_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic [15:0]  l2_address,
    input  logic [127:0] l2_wdata,
    output logic [127:0] l2_rdata,
    output logic         l2_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    lc3b_evb_state    state, state_next;
    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             do_alloc, do_coalesce, do_pop, do_fwd;
    logic             resp_set, rd_capture;

    logic [DEPTH-1:0] match_vec;
    logic             match_any;
    logic [IDX_W-1:0] match_idx;
    logic [127:0]     match_data;
    logic [11:0]      head_tag;
    logic [127:0]     head_data;

    evb_entry_array #(
        .DEPTH (DEPTH)
    ) u_entries (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (do_alloc || do_coalesce),
        .wr_idx     (do_coalesce ? match_idx : tail),
        .wr_tag     (line_tag(l2_address)),
        .wr_data    (l2_wdata),
        .clr_en     (do_pop),
        .clr_idx    (head),
        .lookup_tag (line_tag(l2_address)),
        .match_vec  (match_vec),
        .match_idx  (match_idx),
        .match_data (match_data),
        .head_idx   (head),
        .head_tag   (head_tag),
        .head_data  (head_data)
    );

    assign match_any = |match_vec;

    // Requests are only looked at in IDLE, so a line being drained can never
    // be modified: a write to it waits for the pop and then allocates fresh,
    // which also keeps pmem_wdata stable for the whole pmem transaction.
    always_comb begin
        state_next  = state;
        do_alloc    = 1'b0;
        do_coalesce = 1'b0;
        do_pop      = 1'b0;
        do_fwd      = 1'b0;
        resp_set    = 1'b0;
        rd_capture  = 1'b0;
        case (state)
            IDLE: begin
                // While l2_resp is high the L2 is still holding the request
                // that just completed; sit out this cycle so it is neither
                // accepted twice nor treated as absent (which would start a
                // drain under a request that is about to be replaced).
                if (!l2_resp) begin
                    if (l2_read) begin
                        if (!match_any) begin
                            state_next = RD_MEM;
                        end else begin
`ifdef L2_EVB_FORWARD_EN
                            do_fwd   = 1'b1;
                            resp_set = 1'b1;
`else
                            // A hit implies count > 0: drain until the line
                            // has left the buffer, then read it from pmem.
                            state_next = WR_MEM;
`endif
                        end
                    end else if (l2_write) begin
                        if (match_any) begin
                            do_coalesce = 1'b1;
                            resp_set    = 1'b1;
                        end else if (count != FULL_CNT) begin
                            do_alloc = 1'b1;
                            resp_set = 1'b1;
                        end else begin
                            state_next = WR_MEM;
                        end
                    end else if (count != '0) begin
                        state_next = WR_MEM;
                    end
                end
            end
            RD_MEM: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                    rd_capture = 1'b1;
                    resp_set   = 1'b1;
                end
            end
            WR_MEM: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                    do_pop     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            RD_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = l2_address & LINE_ADDR_MASK;
            end
            WR_MEM: begin
                pmem_write   = 1'b1;
                pmem_address = {head_tag, 4'h0};
                pmem_wdata   = head_data;
            end
            default: begin
            end
        endcase
    end

    // Allocate and pop are mutually exclusive (one completion per cycle),
    // so count never needs a simultaneous +1/-1 case.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            l2_resp  <= 1'b0;
            l2_rdata <= '0;
        end else begin
            state   <= state_next;
            l2_resp <= resp_set;
            if (do_alloc) begin
                tail  <= tail + IDX_W'(1);
                count <= count + CNT_W'(1);
            end
            if (do_pop) begin
                head  <= head + IDX_W'(1);
                count <= count - CNT_W'(1);
            end
            if (rd_capture) begin
                l2_rdata <= pmem_rdata;
            end else if (do_fwd) begin
                l2_rdata <= match_data;
            end
        end
    end

endmodule

// File: tb/tb_l2_eviction_buffer.sv
// Directed scoreboard bench for l2_eviction_buffer (DEPTH=2).
// Latency: checks l2_resp timing/data and the exact pmem transaction order.
// Backpressure: a bench pmem model answers after a programmable number of cycles.
module tb_l2_eviction_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         l2_read, l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l2_eviction_buffer #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_resp      (l2_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_write;
        logic [15:0]  addr;
        logic [127:0] data;
    } pmem_exp_t;

    typedef struct {
        logic         is_read;
        logic [127:0] data;
    } l2_exp_t;

    pmem_exp_t pmem_q[$];
    l2_exp_t   l2_q[$];
    int        checks   = 0;
    int        failures = 0;
    int        pmem_delay = 3;

    localparam logic [127:0] DAT_A  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DAT_B  = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] DAT_C  = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam logic [127:0] DAT_D  = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;
    localparam logic [127:0] DAT_E  = 128'hEEEE_0001_EEEE_0002_EEEE_0003_EEEE_0004;
    localparam logic [127:0] DAT_F  = 128'hFFFF_0001_FFFF_0002_FFFF_0003_FFFF_0004;
    localparam logic [127:0] DAT_G  = 128'h1717_0001_1717_0002_1717_0003_1717_0004;
    localparam logic [127:0] DAT_H  = 128'h1818_0001_1818_0002_1818_0003_1818_0004;
    localparam logic [127:0] DAT_X1 = 128'h0101_1111_0101_1111_0101_1111_0101_1111;
    localparam logic [127:0] DAT_X2 = 128'h0202_2222_0202_2222_0202_2222_0202_2222;
    localparam logic [127:0] DAT_X3 = 128'h0303_3333_0303_3333_0303_3333_0303_3333;

    // pmem contents: a fixed address-derived pattern.
    function automatic logic [127:0] pat(input logic [15:0] a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- pmem model ----------------
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (reset || !(pmem_read || pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= pmem_delay) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = pat(pmem_address);
                    cnt        = 0;
                end
            end
        end
    end

    // ---------------- pmem monitor ----------------
    initial begin
        bit           in_txn;
        logic [127:0] wd_hold;
        pmem_exp_t    e;
        in_txn  = 1'b0;
        wd_hold = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_txn = 1'b0;
            end else begin
                if ((pmem_read || pmem_write) && !in_txn) begin
                    if (pmem_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pmem_unexpected write=%0b addr=%h", pmem_write, pmem_address);
                    end else begin
                        e = pmem_q.pop_front();
                        chk("pmem_is_write", {127'd0, pmem_write}, {127'd0, e.is_write});
                        chk("pmem_address", {112'd0, pmem_address}, {112'd0, e.addr});
                        if (e.is_write) begin
                            chk("pmem_wdata", pmem_wdata, e.data);
                        end
                    end
                    wd_hold = pmem_wdata;
                end else if (in_txn && pmem_write) begin
                    chk("pmem_wdata_stable", pmem_wdata, wd_hold);
                end
                in_txn = (pmem_read || pmem_write) && !pmem_resp;
            end
        end
    end

    // ---------------- l2 response monitor ----------------
    initial begin
        l2_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && l2_resp) begin
                if (l2_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL l2_resp_unexpected rdata=%h", l2_rdata);
                end else begin
                    e = l2_q.pop_front();
                    if (e.is_read) begin
                        chk("l2_rdata", l2_rdata, e.data);
                    end else begin
                        checks++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp_pmem(input logic w, input logic [15:0] a, input logic [127:0] d);
        pmem_exp_t e;
        e.is_write = w;
        e.addr     = a;
        e.data     = d;
        pmem_q.push_back(e);
    endtask

    task automatic l2_req(input logic rd, input logic [15:0] a, input logic [127:0] d);
        l2_address = a;
        l2_wdata   = d;
        l2_read    = rd;
        l2_write   = !rd;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (l2_resp) begin
                l2_read  = 1'b0;
                l2_write = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL l2_timeout addr=%h no l2_resp within 300 cycles", a);
        l2_read  = 1'b0;
        l2_write = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [127:0] d);
        l2_exp_t e;
        e.is_read = 1'b0;
        e.data    = '0;
        l2_q.push_back(e);
        l2_req(1'b0, a, d);
    endtask

    task automatic rd(input logic [15:0] a, input logic [127:0] expd);
        l2_exp_t e;
        e.is_read = 1'b1;
        e.data    = expd;
        l2_q.push_back(e);
        l2_req(1'b1, a, '0);
    endtask

    task automatic wait_drained();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (pmem_q.size() == 0 && !pmem_read && !pmem_write) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout pending_pmem=%0d required=0", pmem_q.size());
    endtask

    task automatic wait_pmem_active();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (pmem_read || pmem_write) return;
        end
        checks++;
        failures++;
        $display("FAIL pmem_start_timeout actual=idle required=active");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l2_resp", {127'd0, l2_resp}, 128'd0);
        chk("rst_l2_rdata", l2_rdata, 128'd0);
        chk("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
        chk("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
        chk("rst_pmem_address", {112'd0, pmem_address}, 128'd0);
        chk("rst_pmem_wdata", pmem_wdata, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single write, low nibble ignored, drained afterwards.
        pmem_delay = 3;
        exp_pmem(1'b1, 16'h1230, DAT_A);
        wr(16'h1237, DAT_A);
        wait_drained();

        // Fill both slots; third write stalls until the oldest drains.
        pmem_delay = 5;
        exp_pmem(1'b1, 16'h1000, DAT_X1);
        exp_pmem(1'b1, 16'h2000, DAT_X2);
        exp_pmem(1'b1, 16'h3000, DAT_X3);
        wr(16'h1000, DAT_X1);
        wr(16'h2000, DAT_X2);
        wr(16'h3000, DAT_X3);
        wait_drained();

        // Read miss waits for an in-flight drain, then bypasses the buffered line.
        pmem_delay = 4;
        exp_pmem(1'b1, 16'h3F00, DAT_F);
        exp_pmem(1'b0, 16'h5000, '0);
        exp_pmem(1'b1, 16'h4000, DAT_B);
        wr(16'h3F00, DAT_F);
        wr(16'h4000, DAT_B);
        wait_pmem_active();
        rd(16'h5000, pat(16'h5000));
        wait_drained();

        // Read hitting a buffered line.
        pmem_delay = 3;
`ifdef L2_EVB_FORWARD_EN
        exp_pmem(1'b1, 16'h4000, DAT_B);
        wr(16'h4000, DAT_B);
        rd(16'h4000, DAT_B);
`else
        exp_pmem(1'b1, 16'h4000, DAT_B);
        exp_pmem(1'b0, 16'h4000, '0);
        wr(16'h4000, DAT_B);
        rd(16'h4000, pat(16'h4000));
`endif
        wait_drained();

        // Coalescing before the drain; no coalescing into a line being drained.
        exp_pmem(1'b1, 16'h6000, DAT_D);
        wr(16'h6000, DAT_C);
        wr(16'h6000, DAT_D);
        wait_drained();
        exp_pmem(1'b1, 16'h6000, DAT_C);
        exp_pmem(1'b1, 16'h6000, DAT_E);
        wr(16'h6000, DAT_C);
        wait_pmem_active();
        wr(16'h6000, DAT_E);
        wait_drained();

        // Reset in the middle of a pmem read with two lines buffered.
        pmem_delay = 20;
        wr(16'h7000, DAT_G);
        wr(16'h8000, DAT_H);
        exp_pmem(1'b0, 16'h9000, '0);
        l2_address = 16'h9000;
        l2_read    = 1'b1;
        wait_pmem_active();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        l2_read = 1'b0;
        @(negedge clk);
        chk("rstmid_pmem_read", {127'd0, pmem_read}, 128'd0);
        chk("rstmid_pmem_write", {127'd0, pmem_write}, 128'd0);
        chk("rstmid_l2_resp", {127'd0, l2_resp}, 128'd0);
        // Buffered lines were dropped: only the new line may reach pmem.
        pmem_delay = 3;
        repeat (10) @(posedge clk);
        #1;
        exp_pmem(1'b1, 16'hA000, DAT_A);
        wr(16'hA000, DAT_A);
        wait_drained();

        repeat (5) @(posedge clk);
        #1;
        chk("l2_queue_empty", 128'(l2_q.size()), 128'd0);
        chk("pmem_queue_empty", 128'(pmem_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
